// File: rtl/sw_capture_pkg.sv
// Shared types and defaults for the slide-switch debounce/capture block.
package sw_capture_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } sw_state_t;

    localparam int SW_STABLE_DEFAULT = 1000000;
    localparam int SW_WIDTH_DEFAULT  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_debounce_capture.sv
// Synchronises and group-debounces the raw slide switches into a stable operand byte.
// Optional commit counter output enabled by defining SW_CHANGE_CNT_EN.
module switch_debounce_capture
    import sw_capture_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH_DEFAULT,
    parameter int STABLE_CYCLES = SW_STABLE_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switch,
    output logic             upd,
    output logic             settling
`ifdef SW_CHANGE_CNT_EN
    ,
    output logic [7:0]       chg_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    sw_state_t        state;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (sw_raw),
        .q     (s2)
    );

    // The whole byte is one event: any bit moving restarts the count, so
    // switch only ever takes a fully settled value.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            switch <= '0;
            upd    <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2 != switch) begin
                        state <= SETTLE;
                        cand  <= s2;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (s2 != cand) begin
                        if (s2 == switch) begin
                            state <= IDLE;
                        end else begin
                            cand <= s2;
                            cnt  <= '0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        switch <= cand;
                        upd    <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign settling = (state == SETTLE);

`ifdef SW_CHANGE_CNT_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            chg_cnt <= '0;
        end else if (upd) begin
            chg_cnt <= chg_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce_capture.sv
// Scoreboard bench: a run-length reference model predicts commits; a negedge monitor checks them.
module tb_switch_debounce_capture;

    localparam int SC = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic         upd;
    logic         settling;
`ifdef SW_CHANGE_CNT_EN
    logic [7:0]   chg_cnt;
`endif

    always #5 clk = ~clk;

    switch_debounce_capture #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .sw_raw   (sw_raw),
        .switch   (sw_out),
        .upd      (upd),
        .settling (settling)
`ifdef SW_CHANGE_CNT_EN
        ,
        .chg_cnt  (chg_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] val;
        int           edge_n;
    } exp_t;

    exp_t sb[$];

    // Reference: the value seen by the debouncer at an edge is the raw input
    // two edges earlier. A commit happens when SC+1 consecutive samples agree
    // on a value different from the current output. Settling is simply
    // "latest sample differs from the output".
    int           cyc = 0;
    logic [W-1:0] d1 = '0, d2 = '0, sw_m = '0, run_v = '0, x;
    int           run_len = 0;
    logic         exp_settle = 1'b0;
    logic [7:0]   exp_chg = '0;

    always @(posedge clk) begin
        cyc++;
        if (!n_rst) begin
            d1 = '0; d2 = '0; sw_m = '0; run_v = '0; run_len = 0;
            exp_settle = 1'b0; exp_chg = '0;
        end else begin
            x = d2;
            if (x == run_v) run_len++;
            else begin
                run_v   = x;
                run_len = 1;
            end
            if (x != sw_m && run_len == SC + 1) begin
                sw_m = x;
                sb.push_back('{x, cyc});
                exp_chg++;
            end
            exp_settle = (x != sw_m);
            d2 = d1;
            d1 = sw_raw;
        end
    end

    bit   mon_en = 1'b0;
    bit   saw_settle = 1'b0;
    int   upd_count = 0;
    int   last_upd = -1;
    exp_t mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("switch", 32'(sw_out), 32'(sw_m));
            check("settling", 32'(settling), 32'(exp_settle));
`ifdef SW_CHANGE_CNT_EN
            check("chg_cnt", 32'(chg_cnt), 32'(exp_chg));
`endif
            if (settling) saw_settle = 1'b1;
            if (upd) begin
                upd_count++;
                last_upd = cyc;
                if (sb.size() == 0) begin
                    check("upd_unexpected", 32'(upd), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("upd_val", 32'(sw_out), 32'(mon_e.val));
                    check("upd_edge", 32'(cyc), 32'(mon_e.edge_n));
                end
            end else if (sb.size() > 0 && sb[0].edge_n <= cyc) begin
                mon_e = sb.pop_front();
                check("upd_missing", 32'(upd), 32'd1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int t0, n0;

        // reset held for three edges with all switches up
        n_rst  = 1'b0;
        sw_raw = 8'hFF;
        repeat (3) @(posedge clk);
        step(1);
        check("rst_switch", 32'(sw_out), 32'h00);
        check("rst_upd", 32'(upd), 32'd0);
        check("rst_settling", 32'(settling), 32'd0);
        sw_raw = 8'h00;
        n_rst  = 1'b1;
        mon_en = 1'b1;
        step(3);

        // clean change: visible with upd after edge SC+2
        sw_raw = 8'hA5;
        t0 = cyc + 1;
        step(SC + 3);
        check("clean_switch", 32'(sw_out), 32'hA5);
        check("clean_upd", 32'(upd), 32'd1);
        check("clean_edge", 32'(last_upd), 32'(t0 + SC + 2));
        step(1);
        check("clean_upd_low", 32'(upd), 32'd0);

        // bounce on bit 7, then hold 8'h80
        sw_raw = 8'h00;
        step(SC + 6);
        n0 = upd_count;
        for (int i = 0; i < 20; i++) begin
            sw_raw = ((i / 2) % 2 != 0) ? 8'h00 : 8'h80;
            step(1);
        end
        sw_raw = 8'h80;
        t0 = cyc + 1;
        check("bounce_quiet", 32'(upd_count), 32'(n0));
        step(SC + 8);
        check("bounce_one_upd", 32'(upd_count), 32'(n0 + 1));
        check("bounce_edge", 32'(last_upd), 32'(t0 + SC + 2));
        check("bounce_switch", 32'(sw_out), 32'h80);

        // short glitch is cancelled
        sw_raw = 8'h00;
        step(SC + 6);
        saw_settle = 1'b0;
        n0 = upd_count;
        sw_raw = 8'h01;
        step(3);
        sw_raw = 8'h00;
        step(8);
        check("glitch_settle_seen", 32'(saw_settle), 32'd1);
        check("glitch_settle_low", 32'(settling), 32'd0);
        check("glitch_no_upd", 32'(upd_count), 32'(n0));
        check("glitch_switch", 32'(sw_out), 32'h00);

        // reset while cnt==2 discards the candidate
        sw_raw = 8'h3C;
        t0 = cyc + 1;
        step(5);
        n_rst = 1'b0;
        n0 = upd_count;
        step(1);
        check("midrst_switch", 32'(sw_out), 32'h00);
        check("midrst_upd", 32'(upd), 32'd0);
        check("midrst_settling", 32'(settling), 32'd0);
        n_rst = 1'b1;
        t0 = cyc + 1;
        step(SC + 4);
        check("midrst_one_upd", 32'(upd_count), 32'(n0 + 1));
        check("midrst_edge", 32'(last_upd), 32'(t0 + SC + 2));
        check("midrst_switch_new", 32'(sw_out), 32'h3C);

        // randomized segments with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                n_rst = 1'b0;
                step(1);
                n_rst = 1'b1;
            end
            case ($urandom_range(0, 3))
                0: sw_raw = 8'($urandom);
                1: sw_raw = sw_raw ^ (8'h01 << $urandom_range(0, 7));
                2: sw_raw = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'hC3;
                default: sw_raw = sw_raw;
            endcase
            step($urandom_range(1, 9));
        end
        step(SC + 10);
        check("sb_drain", 32'(sb.size()), 32'd0);

`ifdef SW_CHANGE_CNT_EN
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        for (int i = 0; i < 257; i++) begin
            sw_raw = (i % 2 != 0) ? 8'h22 : 8'h11;
            step(SC + 4);
        end
        check("chg_cnt_wrap", 32'(chg_cnt), 32'h01);
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
